adder_tree_seq: RTL and testbench

//  Bit-serial MAC sequencer wrapped around the 16-bank adder_tree. Per job, steps input bit index
//  0..IN_BITS-1 (LSB first), issues one bank read per bit, samples the 12-bit tree sum TREE_LAT

---
 rtl/adder_tree_seq_if.sv | 42 ++++
 rtl/adder_tree_seq.sv | 137 +++++++++++++
 tb/tb_adder_tree_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_seq_if.sv
// Handshake and array-side bundle for adder_tree_seq. The slave modport is the sequencer side.
interface adder_tree_seq_if #(
  parameter int unsigned IN_BITS = 8,
  parameter int unsigned SUM_W   = 12
);
  localparam int unsigned ACC_W = SUM_W + IN_BITS;
  localparam int unsigned SEL_W = $clog2(IN_BITS);

  logic             start_valid;
  logic             start_ready;
  logic             rd_en;
  logic [SEL_W-1:0] bit_sel;
  logic [SUM_W-1:0] tree_sum;
  logic             result_valid;
  logic             result_ready;
  logic [ACC_W-1:0] result;
  logic             busy;

  modport master (
    output start_valid,
    input  start_ready,
    input  rd_en,
    input  bit_sel,
    output tree_sum,
    input  result_valid,
    output result_ready,
    input  result,
    input  busy
  );

  modport slave (
    input  start_valid,
    output start_ready,
    output rd_en,
    output bit_sel,
    input  tree_sum,
    output result_valid,
    input  result_ready,
    output result,
    output busy
  );
endinterface

// File: rtl/adder_tree_seq.sv
// Bit-serial MAC sequencer: one bank read per activation bit, accumulates tree_sum << bit.
// Define SIGNED_INPUT_EN to treat activations as two's complement (MSB sample subtracted).
module adder_tree_seq #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned SUM_W    = 12,
  parameter int unsigned TREE_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  adder_tree_seq_if.slave bus
);
  localparam int unsigned ACC_W = SUM_W + IN_BITS;
  localparam int unsigned SEL_W = $clog2(IN_BITS);
  localparam logic [SEL_W-1:0] LastBit = SEL_W'(IN_BITS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;

  // Tag pipe tracks which bit each in-flight read belongs to.
  logic [TREE_LAT-1:0] tag_vld_q;
  logic [SEL_W-1:0]    tag_bit_q [TREE_LAT];

  logic             accept;
  logic             issue;
  logic             sample;
  logic             last_sample;
  logic             handshake;
  logic [SEL_W-1:0] tag_bit;
  logic [ACC_W-1:0] term;

  assign accept      = bus.start_valid && (state_q == StIdle);
  assign issue       = (state_q == StIssue);
  assign sample      = tag_vld_q[TREE_LAT-1];
  assign tag_bit     = tag_bit_q[TREE_LAT-1];
  assign last_sample = sample && (tag_bit == LastBit);
  assign handshake   = result_valid_q && bus.result_ready;
  assign term        = ACC_W'(bus.tree_sum) << tag_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          cnt_d   = '0;
        end
      end
      StIssue: begin
        if (cnt_q == LastBit) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      StDrain: begin
        if (last_sample) state_d = StDone;
      end
      StDone: begin
        if (handshake) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (sample) begin
`ifdef SIGNED_INPUT_EN
      if (tag_bit == LastBit) acc_d = acc_q - term;
      else                    acc_d = acc_q + term;
`else
      acc_d = acc_q + term;
`endif
    end
  end

  // Result is captured one cycle into DONE, once the final sample has landed in acc_q.
  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q;
    if ((state_q == StDone) && !result_valid_q) begin
      result_d       = acc_q;
      result_valid_d = 1'b1;
    end else if (handshake) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < TREE_LAT; i++) tag_bit_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= issue;
      tag_bit_q[0] <= cnt_q;
      for (int unsigned i = 1; i < TREE_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_bit_q[i] <= tag_bit_q[i-1];
      end
    end
  end

  assign bus.start_ready  = (state_q == StIdle);
  assign bus.rd_en        = issue;
  assign bus.bit_sel      = issue ? cnt_q : '0;
  assign bus.busy         = (state_q != StIdle);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_adder_tree_seq.sv
// Bench for adder_tree_seq: two lanes (TREE_LAT 1 and 3) driven in lockstep against a
// registered tree model, with a per-lane result scoreboard.
module tb_adder_tree_seq;
  localparam int unsigned IN_BITS = 8;
  localparam int unsigned SUM_W   = 12;
  localparam int unsigned ACC_W   = SUM_W + IN_BITS;
  localparam int unsigned SEL_W   = $clog2(IN_BITS);

`ifdef SIGNED_INPUT_EN
  localparam logic [ACC_W-1:0] T2Exp  = 20'hFF010;
  localparam logic [ACC_W-1:0] MsbExp = 20'hFFF80;
`else
  localparam logic [ACC_W-1:0] T2Exp  = 20'hFE010;
  localparam logic [ACC_W-1:0] MsbExp = 20'h00080;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start_valid;
  logic result_ready;
  logic [SUM_W-1:0] pat [IN_BITS];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]       sr, rd, rv, bsy, pending;
  logic [SEL_W-1:0] bs  [2];
  logic [ACC_W-1:0] res [2];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [ACC_W-1:0] model();
    longint s = 0;
    for (int b = 0; b < IN_BITS; b++) begin
      longint w = longint'(1) << b;
`ifdef SIGNED_INPUT_EN
      if (b == IN_BITS - 1) w = -w;
`endif
      s += longint'(pat[b]) * w;
    end
    return s[ACC_W-1:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    adder_tree_seq_if #(.IN_BITS(IN_BITS), .SUM_W(SUM_W)) bus ();

    adder_tree_seq #(
      .IN_BITS (IN_BITS),
      .SUM_W   (SUM_W),
      .TREE_LAT(LAT)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    logic [SUM_W-1:0] pipe [LAT];
    logic [ACC_W-1:0] q [$];
    logic             pend = 1'b0;
    logic             vld_prev = 1'b0;
    logic             rdy_prev = 1'b0;
    logic [ACC_W-1:0] res_prev = '0;
    int               acc_cyc = 0;
    int               exp_bit = 0;

    // Garbage on idle slots so a mistimed sample shows up in the sum.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= bus.rd_en ? pat[bus.bit_sel] : 12'hA5A;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign bus.start_valid  = start_valid;
    assign bus.result_ready = result_ready;
    assign bus.tree_sum     = pipe[LAT-1];
    assign sr[g]      = bus.start_ready;
    assign rd[g]      = bus.rd_en;
    assign rv[g]      = bus.result_valid;
    assign bsy[g]     = bus.busy;
    assign bs[g]      = bus.bit_sel;
    assign res[g]     = bus.result;
    assign pending[g] = pend;

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        vld_prev = 1'b0;
        rdy_prev = 1'b0;
        exp_bit  = 0;
      end else begin
        if (bus.start_valid && bus.start_ready) begin
          if (q.size() != 0) check_eq("accept_while_pending", q.size(), 0);
          q.push_back(model());
          acc_cyc = cyc;
          exp_bit = 0;
        end
        if (bus.rd_en) begin
          check_eq("bit_sel", bus.bit_sel, exp_bit);
          check_eq("rd_en_slot", cyc - acc_cyc, exp_bit + 1);
          exp_bit++;
        end
        if (bus.result_valid && !vld_prev) begin
          check_eq("latency", cyc - acc_cyc - 1, IN_BITS + LAT + 1);
          check_eq("rd_en_count", exp_bit, IN_BITS);
        end
        if (vld_prev) begin
          check_eq("result_stable", bus.result, res_prev);
          check_eq("valid_after", bus.result_valid, !rdy_prev);
        end
        if (bus.result_valid && bus.result_ready) begin
          if (q.size() == 0) check_eq("spurious_result", bus.result_valid, 0);
          else check_eq("result", bus.result, q.pop_front());
        end
        vld_prev = bus.result_valid;
        rdy_prev = bus.result_ready;
        res_prev = bus.result;
      end
      pend = (q.size() != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq({tag, "_start_ready"}, sr[g], 1);
      check_eq({tag, "_rd_en"}, rd[g], 0);
      check_eq({tag, "_bit_sel"}, bs[g], 0);
      check_eq({tag, "_result_valid"}, rv[g], 0);
      check_eq({tag, "_result"}, res[g], 0);
      check_eq({tag, "_busy"}, bsy[g], 0);
    end
  endtask

  task automatic set_pat_const(input logic [SUM_W-1:0] v);
    for (int b = 0; b < IN_BITS; b++) pat[b] = v;
  endtask

  task automatic set_pat_rand();
    for (int b = 0; b < IN_BITS; b++) pat[b] = SUM_W'($urandom_range(0, 4080));
  endtask

  task automatic wait_done();
    int n = 0;
    while (pending != 2'b00 && n < 200) begin
      tick();
      n++;
    end
    if (pending != 2'b00) check_eq("job_timeout", pending, 0);
    tick();
    tick();
  endtask

  task automatic run_job();
    check_eq("idle_before_start", sr, 2'b11);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b1;
    set_pat_const('0);
    #3;
    check_reset_vals("por");
    tick();
    tick();
    rst = 1'b0;
    tick();

    set_pat_const(12'd4080);
    run_job();
    check_eq("t2_lane0", res[0], T2Exp);
    check_eq("t2_lane1", res[1], T2Exp);

    set_pat_const('0);
    pat[5] = 12'd1;
    run_job();
    check_eq("t3_bit5", res[0], 32);

    set_pat_const('0);
    pat[IN_BITS-1] = 12'd1;
    run_job();
    check_eq("msb_only", res[1], MsbExp);

    repeat (4) begin
      set_pat_rand();
      run_job();
    end

    // Abort mid-ISSUE at bit 3.
    set_pat_rand();
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    n = 0;
    while (!(rd[0] && bs[0] == 3) && n < 50) begin
      tick();
      n++;
    end
    check_eq("t1_reach_bit3", bs[0], 3);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("t1");
    tick();
    tick();
    rst = 1'b0;
    tick();
    set_pat_rand();
    run_job();

    // Back-pressure with start_valid held high throughout.
    set_pat_rand();
    result_ready = 1'b0;
    start_valid  = 1'b1;
    n = 0;
    while (!rv[0] && n < 50) begin
      tick();
      n++;
    end
    check_eq("t5_valid_seen", rv[0], 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t5_start_blocked", sr, 2'b00);
    end
    check_eq("t5_lane1_valid", rv, 2'b11);
    result_ready = 1'b1;
    check_eq("t5_hs_start_ready", sr, 2'b00);
    tick();
    check_eq("t5_idle_after_hs", sr, 2'b11);
    check_eq("t5_valid_dropped", rv, 2'b00);
    tick();
    check_eq("t5_reaccepted", bsy, 2'b11);
    start_valid = 1'b0;
    wait_done();

    // Start pulses while busy must be ignored.
    set_pat_rand();
    start_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      start_valid = (i % 2 == 1);
      tick();
      check_eq("t6_start_ready_busy", sr, 2'b00);
      check_eq("t6_busy", bsy, 2'b11);
    end
    start_valid = 1'b0;
    wait_done();
    repeat (20) tick();
    check_eq("t6_no_extra_result", rv, 2'b00);
    check_eq("t6_idle", bsy, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
